peripheral_timer: RTL and testbench
===================================

# peripheral_timer

Memory-mapped interval timer for the single-cycle MIPS core. It sits on the data bus beside data memory and drives the `Interrupt` input of the CPU control unit. Software loads a reload value and enables counting; on overflow the counter reloads and, if enabled, raises a sticky interrupt flag. It also provides a free-running system tick counter.

## Interface
- `BASE_ADDR`, 32'h4000_0000, word-aligned base of the register window.
- `PRESCALE`, 1, core cycles per timer tick. Range 1..65536; 1 means one tick per cycle.
- `clk`  in  1  core clock. The only clock.
- `reset`  in  1  synchronous, active-high reset.
- `MemRd`  in  1  bus read strobe. Same signal that feeds data memory.
- `MemWr`  in  1  bus write strobe.
- `addr`  in  32  byte address from the ALU result.
- `wdata`  in  32  store data (rt).
- `rdata`  out  32  read data. Combinational. Valid in the same cycle as `MemRd`.
- `sel`  out  1  high when `addr` falls in [BASE_ADDR, BASE_ADDR+0x1F]. Drives the load-data mux.
- `irqout`  out  1  interrupt request to the control unit's `Interrupt` input.

## Operation
- Register offsets:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: bit0 EN, bit1 IE, bit2 IS (sticky status); bits 31:3 read 0.
  - 0x14 SYSTICK: read-only.
- Any other offset inside the window reads 0; writes to it are ignored.
- `rdata` is 0 whenever `MemRd`=0 or `sel`=0.
- `addr[1:0]` is ignored; accesses are word-only.
- Tick generation:
  - A prescaler counter runs only while EN=1. It counts 0..PRESCALE-1 and issues a one-cycle tick when it wraps.
  - When EN=0, the prescaler holds at 0.
- On each tick:
  - If TL = 32'hFFFF_FFFF: TL <= TH, and if IE=1 then IS <= 1.
  - Otherwise TL <= TL+1. Arithmetic is modulo 2^32.
- `irqout` = IE & IS. It is combinational from registers.
- Kernel-mode masking is not done here; the control unit masks `Interrupt` with PC[31].
- IS is cleared only by a software write of TCON with bit2=0. Writing bit2=1 never sets IS.
- SYSTICK increments every cycle regardless of EN and wraps 32'hFFFF_FFFF -> 0.
- Simultaneous events:
  - Software write to TL in the same cycle as a tick: the write wins and no reload happens.
  - Write to TCON clearing IS in the same cycle as an overflow with IE=1: IS ends at 1, so no interrupt is lost.
  - Write to TH in the same cycle as a reload: the reload uses the old TH.
  - Write to TCON clearing EN: takes effect next cycle. A tick in the current cycle still applies.
  - `MemRd` and `MemWr` both high: the read returns the pre-write value.

## Timing
- Reset (synchronous):
  - TH, TL, TCON, SYSTICK and the prescaler all become 0, so `irqout`=0.
  - Reset asserted mid-count discards all state at the next edge.
- Writes commit at the rising edge of the cycle in which `MemWr`=1.
- Read latency is 0 cycles (combinational).
- Counting:
  - With PRESCALE=1, the first increment lands on the edge after the cycle in which EN was written.
  - With PRESCALE=N, TL changes every N cycles after EN rises.
- Overflow-to-`irqout` latency: `irqout` rises one edge after the tick that sees TL=FFFF_FFFF.
- Period: with TH=T, interrupts recur every (2^32 - T) × PRESCALE cycles.

## Structure
- Package `periph_pkg`:
  - Offset constants `TIMER_TH`, `TIMER_TL`, `TIMER_TCON`, `TIMER_SYSTICK`.
  - TCON bit indices `TCON_EN`, `TCON_IE`, `TCON_IS`.
  - Default `BASE_ADDR`.
- One sub-module: `timer_prescaler`.
  - Inputs: `clk`, `reset`, `en`. Output: `tick`.
  - Parameter: `PRESCALE`.
  - Generates `tick` constantly 1 while `en`=1 when PRESCALE=1.
- Address decode, register file and read mux live in the top module.

## Test plan
- Reset behaviour: assert `reset` for 2 cycles with `MemWr`=1 at TL → all reads return 0, `irqout`=0.
- Basic overflow (PRESCALE=1):
  - Stimulus: write TH=FFFF_FFFC, TL=FFFF_FFFC, TCON=3.
  - Required: TL reads FFFF_FFFD, FFFF_FFFE, FFFF_FFFF, FFFF_FFFC on successive cycles.
  - Required: `irqout` rises on the cycle TL first reads FFFF_FFFC after reload.
- Clear and re-arm:
  - Stimulus: with IS=1, write TCON=1.
  - Required: `irqout`=0 next cycle and TL keeps counting.
  - Stimulus: write TCON=3.
  - Required: the next overflow re-asserts `irqout`.
- Collisions:
  - Stimulus: write TL=5 on the overflow cycle. Required: TL=5 and IS unchanged.
  - Stimulus: clear IS on the overflow cycle. Required: IS reads 1.
- Prescaler (PRESCALE=4):
  - Stimulus: TL=0, TCON=1.
  - Required: TL=1 after 4 cycles and TL=3 after 12 cycles. Clearing EN freezes TL.
- Decode:
  - Read offset 0x0C → 0. Read `addr`=BASE_ADDR+0x20 → `sel`=0, `rdata`=0.
  - Write SYSTICK → ignored; SYSTICK keeps incrementing by 1 per cycle.

Source files
------------

// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped peripherals on the MIPS data bus.
// Register offsets are byte offsets inside the peripheral window.
package periph_pkg;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_0000;

   localparam logic [4:0] TIMER_TH      = 5'h00;
   localparam logic [4:0] TIMER_TL      = 5'h04;
   localparam logic [4:0] TIMER_TCON    = 5'h08;
   localparam logic [4:0] TIMER_SYSTICK = 5'h14;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

   // Word-aligned offset inside the 32-byte window; byte lanes are ignored.
   function automatic logic [4:0] word_off(input logic [31:0] rel);
      return {rel[4:2], 2'b00};
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the core clock into timer ticks; counts only while enabled and
// holds at zero otherwise.
module timer_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         logic w_unused;
         assign w_unused = clk ^ reset;
         assign tick     = en;
      end else begin : g_div
         localparam int CW = $clog2(PRESCALE);
         localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

         logic [CW-1:0] r_cnt;

         always_ff @(posedge clk) begin
            if (reset || !en)
               r_cnt <= '0;
            else if (r_cnt == LAST)
               r_cnt <= '0;
            else
               r_cnt <= r_cnt + 1'b1;
         end

         assign tick = en && (r_cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/peripheral_timer.sv
// Interval timer with reload, sticky interrupt flag and free-running SYSTICK,
// sitting on the MIPS data bus beside data memory.
module peripheral_timer
   import periph_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        sel,
   output logic        irqout
);

   logic [31:0] r_th;
   logic [31:0] r_tl;
   logic [31:0] r_systick;
   logic        r_en;
   logic        r_ie;
   logic        r_is;

   logic [31:0] w_rel;
   logic [4:0]  w_off;
   logic        w_unused;
   logic        w_wr;
   logic        w_wr_th;
   logic        w_wr_tl;
   logic        w_wr_tcon;
   logic        w_tick;
   logic        w_ovf;
   logic        w_is_kept;

   // Subtracting the base keeps the window check correct for any word-aligned base.
   assign w_rel    = addr - BASE_ADDR;
   assign sel      = (w_rel[31:5] == '0);
   assign w_off    = word_off(w_rel);
   assign w_unused = ^w_rel[1:0];

   assign w_wr      = MemWr & sel;
   assign w_wr_th   = w_wr & (w_off == TIMER_TH);
   assign w_wr_tl   = w_wr & (w_off == TIMER_TL);
   assign w_wr_tcon = w_wr & (w_off == TIMER_TCON);

   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (r_en),
      .tick  (w_tick)
   );

   // A software write to TL in the same cycle suppresses both reload and IS set.
   assign w_ovf     = w_tick & (r_tl == 32'hFFFF_FFFF) & ~w_wr_tl;
   assign w_is_kept = w_wr_tcon ? (r_is & wdata[TCON_IS]) : r_is;

   always_ff @(posedge clk) begin
      if (reset)
         r_th <= '0;
      else if (w_wr_th)
         r_th <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_tl <= '0;
      else if (w_wr_tl)
         r_tl <= wdata;
      else if (w_tick)
         r_tl <= w_ovf ? r_th : r_tl + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_en <= 1'b0;
         r_ie <= 1'b0;
      end else if (w_wr_tcon) begin
         r_en <= wdata[TCON_EN];
         r_ie <= wdata[TCON_IE];
      end
   end

   // An overflow in the clearing cycle wins so no interrupt is lost.
   always_ff @(posedge clk) begin
      if (reset)
         r_is <= 1'b0;
      else
         r_is <= w_is_kept | (w_ovf & r_ie);
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_systick <= '0;
      else
         r_systick <= r_systick + 32'd1;
   end

   always_comb begin
      rdata = '0;
      if (MemRd && sel) begin
         case (w_off)
            TIMER_TH:      rdata = r_th;
            TIMER_TL:      rdata = r_tl;
            TIMER_TCON:    rdata = {29'd0, r_is, r_ie, r_en};
            TIMER_SYSTICK: rdata = r_systick;
            default:       rdata = '0;
         endcase
      end
   end

   assign irqout = r_ie & r_is;

endmodule

// File: tb/tb_peripheral_timer.sv
// Randomized scoreboard bench: two timers (PRESCALE 1 and 4) share one bus and
// are checked against a register-level reference model.
module tb_peripheral_timer;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemRd = 1'b0;
   logic        MemWr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata_a, rdata_b;
   logic        sel_a, sel_b, irq_a, irq_b;

   always #5 clk = ~clk;

   peripheral_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut_a (
      .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .addr(addr),
      .wdata(wdata), .rdata(rdata_a), .sel(sel_a), .irqout(irq_a)
   );

   peripheral_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut_b (
      .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .addr(addr),
      .wdata(wdata), .rdata(rdata_b), .sel(sel_b), .irqout(irq_b)
   );

   typedef struct {
      bit          chk;
      bit          rd;
      bit          sel;
      logic [31:0] rdat0;
      logic [31:0] rdat1;
      bit          irq0;
      bit          irq1;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
   int          PS[2] = '{1, 4};
   logic [31:0] m_th[2], m_tl[2], m_sys[2];
   bit          m_en[2], m_ie[2], m_is[2];
   int          m_ecnt[2];
   bit          m_valid = 1'b0;

   function automatic bit in_win(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return o < 32;
   endfunction

   function automatic logic [2:0] widx(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return o[4:2];
   endfunction

   function automatic logic [31:0] mread(input int k);
      if (!MemRd || !in_win(addr)) return 32'd0;
      case (widx(addr))
         3'd0:    return m_th[k];
         3'd1:    return m_tl[k];
         3'd2:    return {29'd0, m_is[k], m_ie[k], m_en[k]};
         3'd5:    return m_sys[k];
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge();
      bit wr_th, wr_tl, wr_tc, tick, ovf;
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            m_th[k] = 0; m_tl[k] = 0; m_sys[k] = 0;
            m_en[k] = 0; m_ie[k] = 0; m_is[k] = 0; m_ecnt[k] = 0;
         end
         m_valid = 1'b1;
      end else begin
         for (int k = 0; k < 2; k++) begin
            wr_th = MemWr && in_win(addr) && widx(addr) == 3'd0;
            wr_tl = MemWr && in_win(addr) && widx(addr) == 3'd1;
            wr_tc = MemWr && in_win(addr) && widx(addr) == 3'd2;
            tick  = m_en[k] && ((m_ecnt[k] + 1) % PS[k] == 0);
            ovf   = tick && m_tl[k] == 32'hFFFF_FFFF && !wr_tl;
            m_ecnt[k] = m_en[k] ? (m_ecnt[k] + 1) % PS[k] : 0;
            if (wr_tl) m_tl[k] = wdata;
            else if (tick) m_tl[k] = (m_tl[k] == 32'hFFFF_FFFF) ? m_th[k] : m_tl[k] + 1;
            if (wr_th) m_th[k] = wdata;
            m_is[k] = (wr_tc ? (m_is[k] & wdata[2]) : m_is[k]) | (ovf & m_ie[k]);
            if (wr_tc) begin
               m_en[k] = wdata[0];
               m_ie[k] = wdata[1];
            end
            m_sys[k] = m_sys[k] + 1;
         end
      end
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
      end
   endtask

   // One bus cycle: expectation is pushed before the edge, model advances after it.
   task automatic cyc(input bit r, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      reset = r; MemRd = rd; MemWr = wr; addr = a; wdata = d;
      e.chk   = m_valid;
      e.rd    = rd;
      e.sel   = in_win(a);
      e.rdat0 = mread(0);
      e.rdat1 = mread(1);
      e.irq0  = m_ie[0] & m_is[0];
      e.irq1  = m_ie[1] & m_is[1];
      q.push_back(e);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rd(input logic [31:0] off);
      cyc(1'b0, 1'b1, 1'b0, BASE + off, 32'd0);
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      cyc(1'b0, 1'b0, 1'b1, BASE + off, d);
   endtask

   task automatic wait_max();
      int n = 0;
      while (m_tl[0] != 32'hFFFF_FFFF && n < 40) begin
         rd(32'h4);
         n++;
      end
      cmp("wait_overflow_bound", {31'd0, m_tl[0] == 32'hFFFF_FFFF}, 32'd1);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.chk) begin
            cmp("sel_a", {31'd0, sel_a}, {31'd0, e.sel});
            cmp("sel_b", {31'd0, sel_b}, {31'd0, e.sel});
            cmp("irq_a", {31'd0, irq_a}, {31'd0, e.irq0});
            cmp("irq_b", {31'd0, irq_b}, {31'd0, e.irq1});
            cmp("rdata_a", rdata_a, e.rdat0);
            cmp("rdata_b", rdata_b, e.rdat1);
         end
      end
   end

   initial begin
      logic [31:0] offs[7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h14, 32'h18, 32'h20};
      logic [31:0] off, d;
      @(posedge clk);
      #1;
      // Reset with a colliding TL write
      cyc(1'b1, 1'b0, 1'b1, BASE + 32'h4, 32'h1234);
      cyc(1'b1, 1'b0, 1'b1, BASE + 32'h4, 32'h1234);
      rd(32'h0); rd(32'h4); rd(32'h8); rd(32'h14);
      // Basic overflow
      wr(32'h0, 32'hFFFF_FFFC); wr(32'h4, 32'hFFFF_FFFC); wr(32'h8, 32'h3);
      repeat (6) rd(32'h4);
      // Clear and re-arm
      wr(32'h8, 32'h1); rd(32'h8); repeat (3) rd(32'h4);
      wr(32'h8, 32'h3); repeat (8) rd(32'h4);
      // TL write on overflow cycle
      wait_max(); wr(32'h4, 32'h5); rd(32'h8); rd(32'h4); rd(32'h4);
      // IS clear colliding with overflow
      wr(32'h8, 32'h3); wr(32'h4, 32'hFFFF_FFFD);
      wait_max(); wr(32'h8, 32'h3); rd(32'h8);
      // TH write on reload cycle
      wait_max(); wr(32'h0, 32'h10); rd(32'h4); rd(32'h4); rd(32'h0);
      // Prescaler
      wr(32'h8, 32'h0); wr(32'h4, 32'h0); wr(32'h8, 32'h1);
      repeat (14) rd(32'h4);
      wr(32'h8, 32'h0); repeat (5) rd(32'h4);
      // Decode
      rd(32'hC);
      cyc(1'b0, 1'b1, 1'b0, BASE + 32'h20, 32'd0);
      cyc(1'b0, 1'b1, 1'b0, BASE - 32'h4, 32'd0);
      wr(32'h14, 32'hDEAD_BEEF); rd(32'h14); rd(32'h14);
      cyc(1'b0, 1'b1, 1'b0, BASE + 32'h7, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, BASE + 32'h4, 32'h77);
      // Random traffic with occasional mid-count reset
      repeat (800) begin
         off = offs[$urandom_range(0, 6)];
         case (off)
            32'h0, 32'h4: d = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF - $urandom_range(0, 6) : $urandom;
            32'h8:        d = {$urandom_range(0, 1) != 0 ? 29'd0 : 29'($urandom), 3'($urandom_range(0, 7))};
            default:      d = $urandom;
         endcase
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
             BASE + off + 32'($urandom_range(0, 3)), d);
      end
      cmp("scoreboard_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
